// File: rtl/nrzi_eop_encoder_pkg.sv
// Shared USB transmit-path types: line states, NRZI/EOP FSM states and J-state line levels.
package usb_pkg;

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_state_t;
  typedef enum logic [1:0] {NE_IDLE, NE_ACTIVE, NE_EOP, NE_EOP_J} nrzi_state_t;

  localparam logic J_DP = 1'b1;
  localparam logic J_DM = 1'b0;
  localparam int unsigned CNT_W = 4;

  // {dp, dm} for a line state; SE1 has no encoding so it can never be driven.
  function automatic logic [1:0] line_bits(input line_state_t ls);
    case (ls)
      LS_J:    line_bits = {J_DP, J_DM};
      LS_K:    line_bits = {~J_DP, ~J_DM};
      default: line_bits = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/nrzi_eop_encoder_counter.sv
// Free-running up counter with synchronous active-high reset and synchronous clear.
module sync_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/nrzi_eop_encoder.sv
// NRZI line encoder with EOP generation (SE0 x EOP_SE0_BITS, then one J) for the USB transmit path.
module nrzi_eop_encoder
  import usb_pkg::*;
#(
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_nrzi,
  input  logic s_in,
  input  logic done,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic eop_done
);

  localparam logic [CNT_W-1:0] SE0_LAST = CNT_W'(EOP_SE0_BITS - 1);

  nrzi_state_t      state;
  logic             lvl;
  logic             lvl_next;
  logic [CNT_W-1:0] se0_cnt;
  logic             cnt_en;
  logic             cnt_clr;

  // A 1 holds the line level, a 0 toggles it; lvl==J_DP means the line sits at J.
  assign lvl_next = s_in ? lvl : ~lvl;
  assign busy     = (state != NE_IDLE);
  assign cnt_en   = (state == NE_EOP);
  assign cnt_clr  = (state == NE_ACTIVE) && done;

  sync_counter #(.W(CNT_W)) u_se0_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (se0_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NE_IDLE;
      lvl      <= J_DP;
      {dp, dm} <= line_bits(LS_J);
      oe       <= 1'b0;
      eop_done <= 1'b0;
    end else begin
      eop_done <= 1'b0;
      case (state)
        NE_IDLE: begin
          if (start_nrzi) begin
            state    <= NE_ACTIVE;
            lvl      <= J_DP;
            {dp, dm} <= line_bits(LS_J);
            oe       <= 1'b1;
          end
        end
        NE_ACTIVE: begin
          // s_in is only consulted here, so X in IDLE or on the done cycle stays off the line.
          if (done) begin
            state    <= NE_EOP;
            {dp, dm} <= line_bits(LS_SE0);
          end else begin
            lvl      <= lvl_next;
            {dp, dm} <= line_bits((lvl_next == J_DP) ? LS_J : LS_K);
          end
        end
        NE_EOP: begin
          if (se0_cnt == SE0_LAST) begin
            state    <= NE_EOP_J;
            {dp, dm} <= line_bits(LS_J);
            eop_done <= 1'b1;
          end
        end
        NE_EOP_J: begin
          state    <= NE_IDLE;
          lvl      <= J_DP;
          {dp, dm} <= line_bits(LS_J);
          oe       <= 1'b0;
        end
        default: begin
          state <= NE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_eop_encoder.sv
// Directed scoreboard bench for nrzi_eop_encoder with EOP_SE0_BITS=2 and EOP_SE0_BITS=3 instances.
module tb_nrzi_eop_encoder;

  logic clk = 1'b0;
  logic rst;
  logic start_a, s_in_a, done_a;
  logic dp_a, dm_a, oe_a, busy_a, eop_done_a;
  logic start_b, s_in_b, done_b;
  logic dp_b, dm_b, oe_b, busy_b, eop_done_b;

  int total = 0;
  int bad   = 0;
  bit sel_b = 1'b0;
  logic [4:0] sb[$];

  // Expected {dp, dm, oe, busy, eop_done}
  localparam logic [4:0] IDL = 5'b10000;
  localparam logic [4:0] JA  = 5'b10110;
  localparam logic [4:0] KA  = 5'b01110;
  localparam logic [4:0] SE0 = 5'b00110;
  localparam logic [4:0] EJ  = 5'b10111;

  nrzi_eop_encoder #(.EOP_SE0_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .start_nrzi(start_a), .s_in(s_in_a), .done(done_a),
    .dp(dp_a), .dm(dm_a), .oe(oe_a), .busy(busy_a), .eop_done(eop_done_a)
  );

  nrzi_eop_encoder #(.EOP_SE0_BITS(3)) dut_b (
    .clk(clk), .rst(rst), .start_nrzi(start_b), .s_in(s_in_b), .done(done_b),
    .dp(dp_b), .dm(dm_b), .oe(oe_b), .busy(busy_b), .eop_done(eop_done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input string tag, input logic r, input logic st, input logic si,
                     input logic dn, input logic [4:0] e);
    logic [4:0] obs;
    logic [4:0] exp_v;
    rst = r;
    if (sel_b) begin
      start_b = st; s_in_b = si; done_b = dn;
      start_a = 1'b0; s_in_a = 1'b0; done_a = 1'b0;
    end else begin
      start_a = st; s_in_a = si; done_a = dn;
      start_b = 1'b0; s_in_b = 1'b0; done_b = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs   = sel_b ? {dp_b, dm_b, oe_b, busy_b, eop_done_b}
                  : {dp_a, dm_a, oe_a, busy_a, eop_done_a};
    exp_v = sb.pop_front();
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    // Reset, then idle with done asserted and s_in unknown
    cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, IDL);
    repeat (5) cyc("idle", 1'b0, 1'b0, 1'bx, 1'b1, IDL);

    // SYNC pattern 0000_0001 then EOP
    cyc("sync_start", 1'b0, 1'b1, 1'bx, 1'b0, JA);
    for (int i = 0; i < 7; i++)
      cyc("sync_bit0", 1'b0, 1'b0, 1'b0, 1'b0, (i % 2 == 0) ? KA : JA);
    cyc("sync_bit1", 1'b0, 1'b0, 1'b1, 1'b0, KA);
    cyc("sync_se0_1", 1'b0, 1'b0, 1'bx, 1'b1, SE0);
    cyc("sync_se0_2", 1'b0, 1'b0, 1'b0, 1'b0, SE0);
    cyc("sync_eop_j", 1'b0, 1'b0, 1'b0, 1'b0, EJ);
    cyc("sync_release", 1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // start and done together in IDLE: start wins; then stuffed run of ones
    cyc("start_done_idle", 1'b0, 1'b1, 1'bx, 1'b1, JA);
    for (int i = 0; i < 6; i++)
      cyc("stuff_hold", 1'b0, (i == 2), 1'b1, 1'b0, JA);
    cyc("stuff_toggle", 1'b0, 1'b0, 1'b0, 1'b0, KA);
    cyc("stuff_se0_1", 1'b0, 1'b0, 1'bx, 1'b1, SE0);
    cyc("stuff_se0_2", 1'b0, 1'b0, 1'b0, 1'b0, SE0);
    cyc("stuff_eop_j", 1'b0, 1'b0, 1'b0, 1'b0, EJ);
    cyc("stuff_release", 1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // start during EOP and EOP_J is dropped; restart begins at J
    cyc("p5_start", 1'b0, 1'b1, 1'b0, 1'b0, JA);
    cyc("p5_bit0", 1'b0, 1'b0, 1'b0, 1'b0, KA);
    cyc("p5_se0_1", 1'b0, 1'b0, 1'bx, 1'b1, SE0);
    cyc("p5_start_in_eop", 1'b0, 1'b1, 1'b0, 1'b0, SE0);
    cyc("p5_eop_j", 1'b0, 1'b0, 1'b0, 1'b0, EJ);
    cyc("p5_start_in_eop_j", 1'b0, 1'b1, 1'b0, 1'b0, IDL);
    cyc("p5_restart", 1'b0, 1'b1, 1'b0, 1'b0, JA);
    cyc("p5_lead0_k", 1'b0, 1'b0, 1'b0, 1'b0, KA);
    cyc("p5_hold_k", 1'b0, 1'b0, 1'b1, 1'b0, KA);

    // Reset mid-ACTIVE, then mid-EOP
    cyc("rst_mid_active", 1'b1, 1'b0, 1'b0, 1'b0, IDL);
    cyc("p6_start", 1'b0, 1'b1, 1'b0, 1'b0, JA);
    cyc("p6_bit1", 1'b0, 1'b0, 1'b1, 1'b0, JA);
    cyc("p6_se0", 1'b0, 1'b0, 1'bx, 1'b1, SE0);
    cyc("rst_mid_eop", 1'b1, 1'b0, 1'b0, 1'b0, IDL);
    cyc("p6_after_rst1", 1'b0, 1'b0, 1'b0, 1'b0, IDL);
    cyc("p6_after_rst2", 1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Three SE0 bit times on the second instance
    sel_b = 1'b1;
    cyc("b_idle", 1'b0, 1'b0, 1'b0, 1'b0, IDL);
    cyc("b_start", 1'b0, 1'b1, 1'b0, 1'b0, JA);
    cyc("b_bit1", 1'b0, 1'b0, 1'b1, 1'b0, JA);
    cyc("b_se0_1", 1'b0, 1'b0, 1'bx, 1'b1, SE0);
    cyc("b_se0_2", 1'b0, 1'b0, 1'b0, 1'b0, SE0);
    cyc("b_se0_3", 1'b0, 1'b0, 1'b0, 1'b0, SE0);
    cyc("b_eop_j", 1'b0, 1'b0, 1'b0, 1'b0, EJ);
    cyc("b_release", 1'b0, 1'b0, 1'b0, 1'b0, IDL);
    cyc("b_idle_after", 1'b0, 1'b0, 1'b0, 1'b0, IDL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
